// File: rtl/inference_sequencer.sv
// rtl/inference_sequencer.sv - Frame controller: weight-load gate, frame FSM, soft-reset stretcher, irq, status.
// Optional COMPUTE watchdog built when SEQ_TIMEOUT_EN is defined.
module inference_sequencer #(
    parameter int NUM_WEIGHTS    = 76976,
    parameter int FRAME_PIXELS   = 131072,
    parameter int RESET_CYCLES   = 15,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_reset_req,
    input  logic        weight_we,
    input  logic        pixel_we,
    input  logic        o_valid,
    input  logic        irq_clear,
    output logic        internal_rst_n,
    output logic        busy,
    output logic        weights_loaded,
    output logic        irq,
    output logic [31:0] status,
    output logic [15:0] frame_count
);

    localparam int PCW = $clog2(FRAME_PIXELS + 1);
    localparam int SCW = $clog2(RESET_CYCLES + 1);
    localparam logic [16:0]    W_LAST = 17'(NUM_WEIGHTS - 1);
    localparam logic [PCW-1:0] P_LAST = PCW'(FRAME_PIXELS - 1);
    localparam logic [SCW-1:0] S_LOAD = SCW'(RESET_CYCLES);

    typedef enum logic [2:0] {
        WAIT_WEIGHTS = 3'd0,
        READY        = 3'd1,
        LOAD         = 3'd2,
        COMPUTE      = 3'd3,
        DONE         = 3'd4,
        ERROR        = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [SCW-1:0] r_stretch_cnt;
    logic [SCW-1:0] w_stretch_next;
    logic [16:0]    r_weight_cnt;
    logic [PCW-1:0] r_pixel_cnt;
    logic           r_internal_rst_n;
    logic           r_weights_loaded;
    logic           r_irq;
    logic [15:0]    r_frame_count;
    logic           r_err_order;
    logic           r_err_overrun;
    logic           w_err_timeout;
    logic           w_timeout_hit;

    logic w_stretching, w_soft_accept, w_clear;
    logic w_weight_ok, w_weight_last, w_frame_done, w_enter_err;
    logic w_cause_order, w_cause_overrun, w_cause_timeout;

    assign w_stretching  = (r_stretch_cnt != '0);
    assign w_soft_accept = soft_reset_req && !w_stretching;
    // Accept cycle and the whole stretch window both scrub the frame-level state.
    assign w_clear       = w_soft_accept || w_stretching;

    assign w_weight_ok   = !w_clear && weight_we &&
                           (r_state == WAIT_WEIGHTS || r_state == READY || r_state == DONE);
    assign w_weight_last = w_weight_ok && (r_weight_cnt == W_LAST);

    assign w_cause_order   = (pixel_we && r_state == WAIT_WEIGHTS) ||
                             (weight_we && (r_state == LOAD || r_state == COMPUTE));
    assign w_cause_overrun = pixel_we && r_state == COMPUTE;
    assign w_cause_timeout = w_timeout_hit && !o_valid && r_state == COMPUTE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_WEIGHTS;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_soft_accept) begin
            w_state_next = r_weights_loaded ? READY : WAIT_WEIGHTS;
        end else if (!w_stretching) begin
            case (r_state)
                WAIT_WEIGHTS: begin
                    if (pixel_we)           w_state_next = ERROR;
                    else if (w_weight_last) w_state_next = READY;
                end
                READY, DONE: begin
                    if (pixel_we) w_state_next = LOAD;
                end
                LOAD: begin
                    if (weight_we)                                w_state_next = ERROR;
                    else if (pixel_we && r_pixel_cnt == P_LAST)   w_state_next = COMPUTE;
                end
                COMPUTE: begin
                    if (weight_we || pixel_we) w_state_next = ERROR;
                    else if (o_valid)          w_state_next = DONE;
                    else if (w_timeout_hit)    w_state_next = ERROR;
                end
                ERROR:   w_state_next = ERROR;
                default: w_state_next = WAIT_WEIGHTS;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == LOAD) || (r_state == COMPUTE);
    end

    assign w_frame_done = !w_clear && r_state == COMPUTE && w_state_next == DONE;
    assign w_enter_err  = !w_clear && r_state != ERROR && w_state_next == ERROR;

    assign w_stretch_next = w_soft_accept ? S_LOAD :
                            (w_stretching ? r_stretch_cnt - SCW'(1) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stretch_cnt    <= '0;
            r_internal_rst_n <= 1'b0;
        end else begin
            r_stretch_cnt    <= w_stretch_next;
            r_internal_rst_n <= (w_stretch_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight_cnt     <= '0;
            r_weights_loaded <= 1'b0;
        end else if (w_clear) begin
            r_weight_cnt     <= '0;
        end else if (w_weight_ok) begin
            r_weight_cnt     <= w_weight_last ? 17'd0 : r_weight_cnt + 17'd1;
            if (w_weight_last) r_weights_loaded <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel_cnt <= '0;
        end else if (w_clear) begin
            r_pixel_cnt <= '0;
        end else if (pixel_we) begin
            if (r_state == READY || r_state == DONE)
                r_pixel_cnt <= PCW'(1);
            else if (r_state == LOAD)
                r_pixel_cnt <= (r_pixel_cnt == P_LAST) ? '0 : r_pixel_cnt + PCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq         <= 1'b0;
            r_frame_count <= '0;
            r_err_order   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else if (w_clear) begin
            r_irq         <= 1'b0;
            r_frame_count <= '0;
            r_err_order   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_irq         <= 1'b1;
                r_frame_count <= r_frame_count + 16'd1;
            end else if (irq_clear) begin
                r_irq <= 1'b0;
            end
            if (w_enter_err && w_cause_order)   r_err_order   <= 1'b1;
            if (w_enter_err && w_cause_overrun) r_err_overrun <= 1'b1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [23:0] r_timeout_cnt;
    logic        r_err_timeout;

    // Counter restarts on every COMPUTE entry; terminal count is the last COMPUTE cycle allowed.
    assign w_timeout_hit = (r_timeout_cnt == 24'(TIMEOUT_CYCLES - 1));
    assign w_err_timeout = r_err_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_cnt <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_timeout_cnt <= (r_state == COMPUTE && w_state_next == COMPUTE) ?
                             r_timeout_cnt + 24'd1 : 24'd0;
            if (w_clear)
                r_err_timeout <= 1'b0;
            else if (w_enter_err && w_cause_timeout)
                r_err_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign w_err_timeout = 1'b0;
`endif

    assign internal_rst_n = r_internal_rst_n;
    assign weights_loaded = r_weights_loaded;
    assign irq            = r_irq;
    assign frame_count    = r_frame_count;
    assign status         = {r_frame_count, 8'h00, w_err_timeout, r_err_overrun,
                             r_err_order, r_irq, r_weights_loaded, r_state};

endmodule

// File: tb/tb_inference_sequencer.sv
// tb/tb_inference_sequencer.sv - Table-driven self-checking bench for inference_sequencer.
module tb_inference_sequencer;

    localparam int NW = 4;
    localparam int FP = 8;
    localparam int RC = 3;
    localparam int TC = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_reset_req = 1'b0;
    logic        weight_we = 1'b0;
    logic        pixel_we = 1'b0;
    logic        o_valid = 1'b0;
    logic        irq_clear = 1'b0;
    logic        internal_rst_n;
    logic        busy;
    logic        weights_loaded;
    logic        irq;
    logic [31:0] status;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    inference_sequencer #(
        .NUM_WEIGHTS(NW), .FRAME_PIXELS(FP), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .soft_reset_req(soft_reset_req),
        .weight_we(weight_we), .pixel_we(pixel_we), .o_valid(o_valid),
        .irq_clear(irq_clear), .internal_rst_n(internal_rst_n), .busy(busy),
        .weights_loaded(weights_loaded), .irq(irq), .status(status),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sr, ww, pw, ov, ic;
        logic        rstn, bsy;
        logic [31:0] st;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic sr, ww, pw, ov, ic,
                                input logic rstn, bsy, input logic [31:0] st);
        vec_t v;
        v.sr = sr; v.ww = ww; v.pw = pw; v.ov = ov; v.ic = ic;
        v.rstn = rstn; v.bsy = bsy; v.st = st;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sr, ww, pw, ov, ic);
        soft_reset_req = sr; weight_we = ww; pixel_we = pw; o_valid = ov; irq_clear = ic;
    endtask

    task automatic wait_rstn_high(input string name);
        int k;
        k = 0;
        while (!internal_rst_n && k < 10) begin
            step();
            k++;
        end
        check(name, {31'b0, internal_rst_n}, 32'd1);
    endtask

    task automatic load_frame();
        for (int k = 0; k < FP; k++) begin
            drive(0, 0, 1, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        int low;

        // Pixel before weights, then soft reset with an ignored weight write mid-stretch
        add(0,0,1,0,0, 1,0, 32'h0000_0025);
        add(1,0,0,0,0, 0,0, 32'h0000_0000);
        add(0,0,0,0,0, 0,0, 32'h0000_0000);
        add(0,1,0,0,0, 0,0, 32'h0000_0000);
        add(0,0,0,0,0, 1,0, 32'h0000_0000);
        for (int k = 0; k < NW - 1; k++) add(0,1,0,0,0, 1,0, 32'h0000_0000);
        add(0,1,0,0,0, 1,0, 32'h0000_0009);
        // First frame
        add(0,0,1,0,0, 1,1, 32'h0000_000A);
        for (int k = 0; k < FP - 2; k++) add(0,0,1,0,0, 1,1, 32'h0000_000A);
        add(0,0,1,0,0, 1,1, 32'h0000_000B);
        for (int k = 0; k < 4; k++) add(0,0,0,0,0, 1,1, 32'h0000_000B);
        add(0,0,0,1,0, 1,0, 32'h0001_001C);
        add(0,0,0,1,0, 1,0, 32'h0001_001C);
        add(0,1,0,0,0, 1,0, 32'h0001_001C);
        // Second frame, irq_clear coinciding with DONE entry
        add(0,0,1,0,0, 1,1, 32'h0001_001A);
        for (int k = 0; k < FP - 2; k++) add(0,0,1,0,0, 1,1, 32'h0001_001A);
        add(0,0,1,0,0, 1,1, 32'h0001_001B);
        add(0,0,0,0,1, 1,1, 32'h0001_000B);
        add(0,0,0,1,1, 1,0, 32'h0002_001C);
        add(0,0,0,0,1, 1,0, 32'h0002_000C);
        add(0,0,0,0,1, 1,0, 32'h0002_000C);
        add(0,1,1,0,0, 1,1, 32'h0002_000A);
        add(0,1,0,0,0, 1,0, 32'h0002_002D);
        // Soft reset keeps weights_loaded; pixel during stretch ignored
        add(1,0,0,0,0, 0,0, 32'h0000_0009);
        add(1,0,0,0,0, 0,0, 32'h0000_0009);
        add(0,0,1,0,0, 0,0, 32'h0000_0009);
        add(0,0,0,0,0, 1,0, 32'h0000_0009);
        // Overrun: simultaneous weight+pixel in READY, then 9th pixel
        add(0,1,1,0,0, 1,1, 32'h0000_000A);
        for (int k = 0; k < FP - 2; k++) add(0,0,1,0,0, 1,1, 32'h0000_000A);
        add(0,0,1,0,0, 1,1, 32'h0000_000B);
        add(0,0,1,0,0, 1,0, 32'h0000_004D);
        add(0,0,0,1,0, 1,0, 32'h0000_004D);
        add(1,0,0,0,0, 0,0, 32'h0000_0009);

        #3;
        check("reset_rstn", {31'b0, internal_rst_n}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_status", status, 32'd0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sr, vecs[i].ww, vecs[i].pw, vecs[i].ov, vecs[i].ic);
            step();
            check($sformatf("vec%0d_rstn", i), {31'b0, internal_rst_n}, {31'b0, vecs[i].rstn});
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].bsy});
            check($sformatf("vec%0d_status", i), status, vecs[i].st);
        end
        drive(0, 0, 0, 0, 0);

        // Stretch width with a second request landing mid-stretch
        wait_rstn_high("stretch_release");
        low = 0;
        for (int k = 0; k < 8; k++) begin
            drive((k < 2) ? 1'b1 : 1'b0, 0, 0, 0, 0);
            step();
            if (!internal_rst_n) low++;
        end
        drive(0, 0, 0, 0, 0);
        check("stretch_low_cycles", low, RC);
        check("stretch_wl_kept", {31'b0, weights_loaded}, 32'd1);
        check("stretch_status", status, 32'h0000_0009);

`ifdef SEQ_TIMEOUT_EN
        load_frame();
        for (int k = 0; k < TC - 1; k++) step();
        check("timeout_pre", status, 32'h0000_000B);
        step();
        check("timeout_hit", status, 32'h0000_008D);
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        wait_rstn_high("timeout_recover");
        load_frame();
        for (int k = 0; k < TC - 1; k++) step();
        drive(0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("timeout_valid_wins", status, 32'h0001_001C);
`endif

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rstn", {31'b0, internal_rst_n}, 32'd0);
        check("async_status", status, 32'd0);
        check("async_frame_count", {16'b0, frame_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
